// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the IF / D memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Grant selection between IF and D: D wins ties unless IF has waited through
// MAX_DATA_STREAK consecutive D grants.
module arb_grant_sel #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic d_valid,
    input  logic idle,
    output logic grant_if,
    output logic grant_d
);

    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                if_forced;

    always_comb begin
        if_forced = (streak_q == STREAK_MAX);
        grant_d   = idle && d_valid && !(if_valid && if_forced);
        grant_if  = idle && if_valid && !grant_d;
        streak_d  = streak_q;
        // The streak only moves while idle; a busy arbiter leaves it untouched.
        if (idle) begin
            if (grant_if || !if_valid) begin
                streak_d = '0;
            end else if (grant_d && !if_forced) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and D loads/stores onto one single-port memory,
// returning each result as a one-cycle response pulse on the requesting port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_write_enabled,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              busy
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_e             port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              idle;
    logic              grant_if, grant_d;
    logic [ADDR_W-1:0] sel_addr;

    // Gating with rst keeps both ready outputs low while reset is held.
    assign idle = (state_q == ST_IDLE) && rst;

    arb_grant_sel #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_grant_sel (
        .clk     (clk),
        .rst     (rst),
        .if_valid(if_req_valid),
        .d_valid (d_req_valid),
        .idle    (idle),
        .grant_if(grant_if),
        .grant_d (grant_d)
    );

    assign sel_addr = grant_d ? d_addr : if_addr;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d           = state_q;
        cnt_d             = cnt_q;
        port_d            = port_q;
        we_d              = we_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        err_d             = err_q;
        mem_write_enabled = 1'b0;
        mem_addr          = '0;
        mem_w_data        = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_d || grant_if) begin
                    port_d  = grant_d ? PORT_D : PORT_IF;
                    we_d    = grant_d && d_we;
                    addr_d  = sel_addr;
                    wdata_d = grant_d ? d_wdata : '0;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = is_misaligned(sel_addr[1:0]);
                    state_d = is_misaligned(sel_addr[1:0]) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_addr          = addr_q;
                mem_w_data        = wdata_q;
                mem_write_enabled = we_q && (cnt_q == '0);
                if (cnt_q == LAST_CNT) begin
                    rdata_d = we_q ? '0 : mem_r_data;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            port_q  <= PORT_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign if_req_ready  = grant_if;
    assign d_req_ready   = grant_d;
    assign busy          = (state_q != ST_IDLE);

    assign if_resp_valid = (state_q == ST_RESP) && (port_q == PORT_IF);
    assign d_resp_valid  = (state_q == ST_RESP) && (port_q == PORT_D);
    assign if_rdata      = if_resp_valid ? rdata_q : '0;
    assign if_err        = if_resp_valid && err_q;
    assign d_rdata       = d_resp_valid ? rdata_q : '0;
    assign d_err         = d_resp_valid && err_q;

endmodule
